// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } arb_state_e;

  // Widest requester vector the picker function handles.
  localparam int MAX_REQ = 8;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // One-hot winner: first set bit of req[n-1:0] scanning upward from last+1 with wrap.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [2:0]         last,
                                                  input int                 n);
    logic [MAX_REQ-1:0] win;
    int idx;
    win = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && win == '0 && req[idx[2:0]]) win[idx[2:0]] = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams and the shared UART TX byte sink, bundled for the arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  // Valid/ready: a byte moves exactly on a cycle where valid && ready; the source
  // holds data/last stable while valid && !ready, and ready never depends on a
  // later valid.
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_data_valid;
  logic                    tx_data_ready;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  arb_state_e              state_dbg;

  modport master (
    output req_data, req_valid, req_last, tx_data_ready,
    input  req_ready, tx_data, tx_data_valid, grant, busy, state_dbg
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_data_ready,
    output req_ready, tx_data, tx_data_valid, grant, busy, state_dbg
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: lowest-numbered request after `last` wins.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any
);
  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] win_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    win_ext        = rr_pick(req_ext, 3'(last), N);
    winner         = win_ext[N-1:0];
    winner_idx     = '0;
    for (int i = 0; i < N; i++) begin
      if (winner[i]) winner_idx = IDX_W'(i);
    end
    any = |req;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART TX byte sink between N_REQ streams.
// Optional stall timeout release: define UART_TX_ARB_HOLD_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 64,
  parameter int HOLD_TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arbiter_if.slave bus
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
  ,
  output logic            timeout_pulse
`endif
);
  localparam int IDX_W = clog2(N_REQ);
  localparam int CNT_W = clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  if (N_REQ < 2 || N_REQ > MAX_REQ || MAX_BURST < 1 || MAX_BURST > 65535 || HOLD_TIMEOUT < 1)
  begin : g_param_range
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_e        state, state_nxt;
  logic [N_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_last;
  logic [CNT_W-1:0]  byte_cnt;

  logic [N_REQ-1:0]  pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic              xfer;
  logic              owner_valid;
  logic              owner_last;
  logic              fire;
  logic              timeout_hit;
  logic              release_now;
  logic [DATA_W-1:0] tx_mux;

  uart_rr_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req        (bus.req_valid),
    .last       (rr_last),
    .winner     (pick),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  // Owner stream is forwarded straight through; reset masks both handshake sides.
  always_comb begin
    xfer        = (state == S_XFER) && !rst;
    owner_valid = bus.req_valid[owner];
    owner_last  = bus.req_last[owner];
    tx_mux      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IDX_W'(i)) tx_mux = bus.req_data[i*DATA_W +: DATA_W];
    end
    bus.tx_data       = tx_mux;
    bus.tx_data_valid = xfer && owner_valid;
    bus.req_ready     = '0;
    if (xfer) bus.req_ready[owner] = bus.tx_data_ready;
    fire        = bus.tx_data_valid && bus.tx_data_ready;
    release_now = (fire && (owner_last || byte_cnt == BURST_LAST)) || timeout_hit;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_any) state_nxt = S_XFER;
      S_XFER:  if (release_now) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      grant_q  <= '0;
      owner    <= '0;
      rr_last  <= IDX_W'(N_REQ - 1);
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            grant_q  <= pick;
            owner    <= pick_idx;
            rr_last  <= pick_idx;
            byte_cnt <= '0;
          end
        end
        S_XFER: begin
          if (release_now) grant_q <= '0;
          if (fire && byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
        end
        default: grant_q <= '0;
      endcase
    end
  end

`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
  localparam int ST_W = clog2(HOLD_TIMEOUT) + 1;
  localparam logic [ST_W-1:0] STALL_LAST = ST_W'(HOLD_TIMEOUT - 1);

  logic [ST_W-1:0] stall_cnt;

  // Counts consecutive owner-idle cycles in S_XFER; any owner valid restarts it.
  always_ff @(posedge clk) begin
    if (rst || state != S_XFER || owner_valid) stall_cnt <= '0;
    else if (!timeout_hit)                     stall_cnt <= stall_cnt + 1'b1;
  end

  assign timeout_hit   = xfer && !owner_valid && (stall_cnt == STALL_LAST);
  assign timeout_pulse = timeout_hit;
`else
  assign timeout_hit = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.busy      = (state == S_XFER);
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, MAX_BURST=4, HOLD_TIMEOUT=8).
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int HT = 8;

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
  logic timeout_pulse;
`endif

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  logic [8:0]   src_mem [N][8];
  int           src_len [N];
  int           src_ptr [N];
  logic [N-1:0] src_en;
  logic [N-1:0] src_stall;
  logic         tx_rdy;
  logic         rst_v;
  logic [N-1:0] hs;

  logic [11:0]  exp_q[$];
  int           fires;
  int           tick_no;
  int           burst_cnt;
  int           gcnt [N];
  int           pulse_cnt;
  int           pulse_tick;
  logic         pend_release;
  logic         held_v;
  logic [7:0]   held_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int owner_of(input logic [N-1:0] g);
    int o;
    o = 0;
    for (int i = 0; i < N; i++) if (g[i]) o = i;
    return o;
  endfunction

  function automatic logic sources_done();
    logic d;
    d = 1'b1;
    for (int i = 0; i < N; i++) if (src_en[i] && src_ptr[i] < src_len[i]) d = 1'b0;
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    d = '0; v = '0; l = '0;
    for (int i = 0; i < N; i++) begin
      if (src_en[i] && !src_stall[i] && src_ptr[i] < src_len[i]) begin
        v[i]         = 1'b1;
        d[i*W +: W]  = src_mem[i][src_ptr[i]][7:0];
        l[i]         = src_mem[i][src_ptr[i]][8];
      end
    end
    bus.req_data  = d;
    bus.req_valid = v;
    bus.req_last  = l;
  endtask

  task automatic load_src(input int i, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) src_mem[i][k] = {(k == n - 1), 8'(base + k)};
    src_len[i]   = n;
    src_ptr[i]   = 0;
    src_en[i]    = 1'b1;
    src_stall[i] = 1'b0;
  endtask

  task automatic push_exp(input int i, input logic [7:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) exp_q.push_back({4'(i), 8'(base + k)});
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic monitor();
    logic        fire;
    logic [11:0] obs;
    int          o;
    hs   = bus.req_valid & bus.req_ready;
    fire = bus.tx_data_valid && bus.tx_data_ready;
    check("grant_onehot", 32'($onehot0(bus.grant)), 32'd1);
    if (pend_release) begin
      check("bubble_grant", 32'(bus.grant), 32'd0);
      check("bubble_busy", 32'(bus.busy), 32'd0);
      pend_release = 1'b0;
    end
    if (bus.grant == '0) burst_cnt = 0;
    for (int i = 0; i < N; i++) if (bus.grant == N'(1 << i)) gcnt[i]++;
    if (held_v && bus.tx_data_valid) check("hold_data", 32'(bus.tx_data), 32'(held_d));
    held_v = bus.tx_data_valid && !bus.tx_data_ready;
    held_d = bus.tx_data;
    if (fire) begin
      o   = owner_of(bus.grant);
      obs = {4'(o), bus.tx_data};
      if (exp_q.size() == 0) check("tx_byte_extra", 32'(obs), 32'hffff_ffff);
      else                   check("tx_byte", 32'(obs), 32'(exp_q.pop_front()));
      fires++;
      if (bus.req_last[o] || burst_cnt == MB - 1) pend_release = 1'b1;
      burst_cnt++;
    end
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
    if (timeout_pulse) begin
      pulse_cnt++;
      pulse_tick = tick_no;
    end
`endif
  endtask

  // One clock: apply pops/controls after the edge, sample at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) src_ptr[i]++;
    rst               = rst_v;
    bus.tx_data_ready = tx_rdy;
    drive();
    tick_no++;
    @(negedge clk);
    monitor();
  endtask

  task automatic reset_dut();
    src_en    = '0;
    src_stall = '0;
    exp_q.delete();
    rst_v = 1'b1;
    tick();
    tick();
    rst_v = 1'b0;
    tick();
  endtask

  task automatic wait_fires(input int target, input string tag);
    int c;
    c = 0;
    while (fires < target && c < 200) begin
      tick();
      c++;
    end
    check(tag, 32'(fires >= target), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && sources_done()) && c < 300) begin
      tick();
      c++;
    end
    tick();
    tick();
    check(tag, 32'(exp_q.size() == 0 && sources_done()), 32'd1);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int f0;
    int g0;
    int t0;
    int gs [N];

    rst = 1'b1;
    bus.req_data = '0; bus.req_valid = '0; bus.req_last = '0; bus.tx_data_ready = 1'b1;
    src_en = '0; src_stall = '0; tx_rdy = 1'b1; rst_v = 1'b1; hs = '0;
    fires = 0; tick_no = 0; burst_cnt = 0; pulse_cnt = 0; pulse_tick = 0;
    pend_release = 1'b0; held_v = 1'b0; held_d = '0;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0; src_ptr[i] = 0; gcnt[i] = 0;
    end

    tick();
    tick();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_data_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
    rst_v = 1'b0;
    tick();

    // Test 1: single requester, three-byte message.
    load_src(0, 8'h41, 3);
    push_exp(0, 8'h41, 0, 2);
    g0 = gcnt[0];
    wait_drain("t1_drain");
    check("t1_grant_cycles", 32'(gcnt[0] - g0), 32'd3);

    // Test 2: all four start together; round-robin from requester 0.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      gs[i] = gcnt[i];
      load_src(i, 8'(8'hA0 + 16 * i), 2);
      push_exp(i, 8'(8'hA0 + 16 * i), 0, 1);
    end
    wait_drain("t2_drain");
    for (int i = 0; i < N; i++) check($sformatf("t2_grant_cycles_%0d", i), 32'(gcnt[i] - gs[i]), 32'd2);

    // Test 3: burst limit splits requester 1's six-byte message around requester 2.
    reset_dut();
    load_src(1, 8'h10, 6);
    load_src(2, 8'h20, 2);
    push_exp(1, 8'h10, 0, 3);
    push_exp(2, 8'h20, 0, 1);
    push_exp(1, 8'h10, 4, 5);
    wait_drain("t3_drain");

    // Test 4: TX backpressure for ten cycles mid-message.
    reset_dut();
    load_src(0, 8'h30, 5);
    push_exp(0, 8'h30, 0, 4);
    f0 = fires;
    wait_fires(f0 + 2, "t4_first_bytes");
    tx_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 5) begin
        check("t4_req_ready", 32'(bus.req_ready), 32'd0);
        check("t4_tx_valid", 32'(bus.tx_data_valid), 32'd1);
        check("t4_tx_data", 32'(bus.tx_data), 32'h32);
      end
    end
    check("t4_no_fire", 32'(fires - f0), 32'd2);
    tx_rdy = 1'b1;
    wait_drain("t4_drain");

    // Test 5: owner stalls mid-message with requester 1 pending.
    reset_dut();
    load_src(0, 8'h60, 4);
    load_src(1, 8'h70, 2);
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
    push_exp(0, 8'h60, 0, 1);
    push_exp(1, 8'h70, 0, 1);
    push_exp(0, 8'h60, 2, 3);
`else
    push_exp(0, 8'h60, 0, 3);
    push_exp(1, 8'h70, 0, 1);
`endif
    f0 = fires;
    wait_fires(f0 + 2, "t5_first_bytes");
    src_stall[0] = 1'b1;
    t0 = tick_no;
    for (int k = 0; k < 20; k++) tick();
`ifdef UART_TX_ARB_HOLD_TIMEOUT_EN
    check("t5_pulse_count", 32'(pulse_cnt), 32'd1);
    check("t5_pulse_tick", 32'(pulse_tick - t0), 32'd8);
`else
    check("t5_grant_held", 32'(bus.grant), 32'b0001);
    check("t5_busy_held", 32'(bus.busy), 32'd1);
    check("t5_no_fire", 32'(fires - f0), 32'd2);
`endif
    src_stall[0] = 1'b0;
    wait_drain("t5_drain");

    // Test 6: one-cycle reset during byte 2; round-robin restarts at requester 0.
    reset_dut();
    load_src(2, 8'h80, 4);
    push_exp(2, 8'h80, 0, 3);
    f0 = fires;
    wait_fires(f0 + 1, "t6_first_byte");
    rst_v = 1'b1;
    tick();
    check("t6_rst_tx_valid", 32'(bus.tx_data_valid), 32'd0);
    check("t6_rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_v     = 1'b0;
    src_en[2] = 1'b0;
    tick();
    check("t6_grant", 32'(bus.grant), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_tx_valid", 32'(bus.tx_data_valid), 32'd0);
    exp_q.delete();
    load_src(2, 8'h80, 4);
    load_src(3, 8'h90, 2);
    push_exp(2, 8'h80, 0, 3);
    push_exp(3, 8'h90, 0, 1);
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (uart_tx-style byte sink with tx_data/tx_data_valid/tx_data_ready) between N_REQ byte-stream requesters. Arbitration is round-robin at message granularity. A grant is held until the requester's last byte, or until MAX_BURST bytes have been sent. Sits between on-chip message sources (status reporter, echo path, debug dump) and the single TX instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
MAX_BURST, 64, max bytes per grant before forced release (1..65535)
HOLD_TIMEOUT, 1000, stall cycles before forced release (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_data  in  N_REQ*DATA_W  requester bytes; requester i uses bits [i*DATA_W +: DATA_W]
req_valid  in  N_REQ  byte valid per requester
req_last  in  N_REQ  marks final byte of a message; qualified by req_valid
req_ready  out  N_REQ  byte accepted when req_valid&req_ready
tx_data  out  DATA_W  byte to UART TX
tx_data_valid  out  1  byte valid to TX
tx_data_ready  in  1  TX accepts byte
grant  out  N_REQ  registered one-hot current owner; 0 when idle
busy  out  1  high in S_XFER

Behaviour:
- Reset (sync, active-high, synchronous to clk): state=S_IDLE, grant=0, busy=0, byte_cnt=0, rr_last=N_REQ-1 (requester 0 has highest priority first). During reset req_ready=0 and tx_data_valid=0.
- FSM has two states:
  - S_IDLE: if any req_valid, pick the first set bit scanning from rr_last+1 upward with wrap. Register grant, set rr_last=winner, byte_cnt=0, go to S_XFER. Else stay.
  - S_XFER: combinational forward of the owner's stream: tx_data=req_data[owner], tx_data_valid=req_valid[owner], req_ready[owner]=tx_data_ready. All other req_ready are 0.
- Handshake: a transfer occurs when tx_data_valid&tx_data_ready; byte_cnt increments on each transfer.
- Release on a transfer with req_last[owner]=1 OR byte_cnt==MAX_BURST-1. Release means grant cleared and state returns to S_IDLE next cycle. A coincident last and burst limit gives a single release.
- Latency: a request seen in S_IDLE at cycle t gives grant/busy at t+1, and the first byte is presentable at t+1. After a release at t, the earliest next grant is t+2 (one idle bubble).
- If the owner deasserts req_valid mid-message, the grant is held indefinitely (without the optional feature). tx_data_valid drops; tx_data is don't-care.
- Non-owners' req_valid/req_last are ignored while in S_XFER. Requesters must hold data stable while valid&&!ready.
- tx_data_valid must never be asserted while tx_data_ready is ignored: no byte is dropped or duplicated.
- byte_cnt width is clog2(MAX_BURST)+1 bits and saturates cleanly. The MAX_BURST=1 case releases after every byte.
- Reset mid-message drops the grant immediately. Any partial message is abandoned, and the requester restarts it.

Optional Feature:
Macro UART_TX_ARB_HOLD_TIMEOUT_EN.
- Defined: a stall counter increments each S_XFER cycle with req_valid[owner]=0 and clears on any owner valid. Reaching HOLD_TIMEOUT-1 forces release and pulses the extra output port timeout_pulse (1 bit, 1 cycle).
- Undefined: no counter, no timeout_pulse port; a stalled owner holds the grant forever.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding S_IDLE/S_XFER
  - function rr_pick(req, last) returning a one-hot winner
  - clog2 helper
- One natural sub-module: uart_rr_picker, a combinational rotate-priority-encoder. It is instantiated once and is reusable for the future RX-side command demux.

Test Plan:
- Single requester: req 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_data_ready always 1 -> tx sees exactly 41,42,43; grant=0001 for 3 cycles; busy drops the cycle after 0x43.
- All 4 requesters each send a 2-byte message starting the same cycle -> grant order 0,1,2,3; one idle cycle between messages; 8 bytes delivered with no interleaving.
- MAX_BURST=4; req 1 sends 6 bytes with no last before byte 6, while req 2 is pending -> bytes 1-4 from req1, then req2's message, then req1 bytes 5-6.
- Backpressure: tx_data_ready low for 10 cycles mid-message -> tx_data stable and held; req_ready low; no loss or duplication when ready returns.
- Owner stalls 20 cycles mid-message with another request pending -> grant held, no switch. With UART_TX_ARB_HOLD_TIMEOUT_EN and HOLD_TIMEOUT=8 -> timeout_pulse at stall cycle 8 and the other requester is granted.
- Assert rst for 1 cycle during byte 2 of a message -> grant=0, busy=0, tx_data_valid=0 next cycle; rr restarts at requester 0.
